// File: rtl/mc_core_pkg.sv
// Shared types and encodings for the multicycle core sequencer.
// State values are fixed because state_o exposes them for debug.
package mc_core_pkg;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_ADDR   = 4'd5,
        S_MEM_RD = 4'd6,
        S_MEM_WR = 4'd7,
        S_WB_ALU = 4'd8,
        S_WB_MEM = 4'd9,
        S_BRANCH = 4'd10,
        S_JAL    = 4'd11,
        S_LUI    = 4'd12,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [11:0] F12_EBREAK = 12'h001;

    localparam logic       ADDR_PC       = 1'b0;
    localparam logic       ADDR_ALUOUT   = 1'b1;
    localparam logic       PC_SRC_ALU    = 1'b0;
    localparam logic       PC_SRC_ALUOUT = 1'b1;

    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_RS1   = 2'd1;
    localparam logic [1:0] ALU_A_OLDPC = 2'd2;

    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_FOUR = 2'd1;
    localparam logic [1:0] ALU_B_IMM  = 2'd2;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_SUB   = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd2;
    localparam logic [1:0] ALU_OP_PASSB = 2'd3;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd2;
    localparam logic [1:0] TRAP_EBREAK  = 2'd3;

    function automatic logic is_wait_state(input state_t s);
        return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    endfunction

endpackage

// File: rtl/mc_mem_watchdog.sv
// Counts unanswered memory-request cycles and flags a timeout on the
// last allowed cycle; a ready in that same cycle suppresses the flag.
module mc_mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (active_i && !ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign timeout_o = active_i && !ready_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_core_ctrl.sv
// Multicycle RV32I-subset sequencer: steps fetch/decode/execute/memory/
// writeback, drives datapath selects and parks in a sticky TRAP state.
module mc_core_ctrl
    import mc_core_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [11:0] funct12,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic [1:0]  alu_a,
    output logic [1:0]  alu_b,
    output logic [1:0]  alu_op,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        halt,
    output logic [1:0]  trap_cause,
    output logic [3:0]  state_o
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       wd_clear, wd_active, wd_timeout;

    // Counter restarts whenever a wait state is freshly entered.
    assign wd_active = is_wait_state(state_q);
    assign wd_clear  = (state_d != state_q) && is_wait_state(state_d);

    mc_mem_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wd (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (wd_clear),
        .active_i (wd_active),
        .ready_i  (mem_ready),
        .timeout_o(wd_timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            S_INIT:   state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (wd_timeout) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:               state_d = S_EXEC_R;
                    OP_I:               state_d = S_EXEC_I;
                    OP_LOAD, OP_STORE:  state_d = S_ADDR;
                    OP_BRANCH:          state_d = S_BRANCH;
                    OP_JAL:             state_d = S_JAL;
                    OP_LUI:             state_d = S_LUI;
                    OP_SYSTEM: begin
                        state_d = S_TRAP;
                        cause_d = (funct12 == F12_EBREAK) ? TRAP_EBREAK : TRAP_ILLEGAL;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = TRAP_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_WB_ALU;
            S_ADDR:   state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (wd_timeout) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (wd_timeout) begin
                    state_d = S_TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL: state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_INIT;
        endcase
    end

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = ADDR_PC;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_src   = PC_SRC_ALU;
        alu_a    = ALU_A_PC;
        alu_b    = ALU_B_RS2;
        alu_op   = ALU_OP_ADD;
        rf_we    = 1'b0;
        wb_sel   = WB_ALUOUT;
        halt     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                alu_b   = ALU_B_FOUR;
                ir_we   = mem_ready;
                pc_we   = mem_ready;
            end
            S_DECODE: begin
                alu_a = ALU_A_OLDPC;
                alu_b = ALU_B_IMM;
            end
            S_EXEC_R: begin
                alu_a  = ALU_A_RS1;
                alu_op = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
                alu_a  = ALU_A_RS1;
                alu_b  = ALU_B_IMM;
                alu_op = ALU_OP_FUNCT;
            end
            S_LUI: begin
                alu_b  = ALU_B_IMM;
                alu_op = ALU_OP_PASSB;
            end
            S_ADDR: begin
                alu_a = ALU_A_RS1;
                alu_b = ALU_B_IMM;
            end
            S_MEM_RD: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_ALUOUT;
            end
            S_MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = ADDR_ALUOUT;
            end
            S_WB_ALU: rf_we = 1'b1;
            S_WB_MEM: begin
                rf_we  = 1'b1;
                wb_sel = WB_MDR;
            end
            S_BRANCH: begin
                alu_a  = ALU_A_RS1;
                alu_op = ALU_OP_SUB;
                pc_src = PC_SRC_ALUOUT;
                pc_we  = zero;
            end
            S_JAL: begin
                rf_we  = 1'b1;
                wb_sel = WB_PC;
                pc_we  = 1'b1;
                pc_src = PC_SRC_ALUOUT;
            end
            S_TRAP:  halt = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign state_o    = state_q;

endmodule
